// File: rtl/mmio_uart_tx.sv
// Memory-mapped 8N1 UART transmitter with a 4-entry byte FIFO, sticky overflow
// flag and a level interrupt raised when the transmitter has drained completely.
module mmio_uart_tx #(
  parameter int BAUD_DIV = 10417
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        rd,
  input  logic        wr,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        uart_tx,
  output logic        irq
);

  localparam logic [31:0] ADDR_TXDATA = 32'h4000_0030;
  localparam logic [31:0] ADDR_STATUS = 32'h4000_0034;
  localparam logic [31:0] ADDR_CTRL   = 32'h4000_0038;
  localparam logic [15:0] BAUD_LAST   = 16'(BAUD_DIV - 1);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t      state_q, state_d;
  logic [15:0] baud_q, baud_d;
  logic [2:0]  bit_q, bit_d;
  logic [7:0]  shift_q, shift_d;
  logic        tx_q, tx_d;
  logic        irq_q, irq_d;
  logic        ovf_q, ovf_d;
  logic        irq_en_q, irq_en_d;
  logic [7:0]  mem_q [4];
  logic [7:0]  mem_d [4];
  logic [1:0]  wptr_q, wptr_d;
  logic [1:0]  rptr_q, rptr_d;
  logic [2:0]  cnt_q, cnt_d;

  logic sel_tx, sel_status, sel_ctrl;
  logic full, empty, busy, push_req, push, pop, baud_end;
  logic unused_wdata;

  assign unused_wdata = ^wdata[31:8];

  assign sel_tx     = (addr == ADDR_TXDATA);
  assign sel_status = (addr == ADDR_STATUS);
  assign sel_ctrl   = (addr == ADDR_CTRL);
  assign full       = (cnt_q == 3'd4);
  assign empty      = (cnt_q == 3'd0);
  assign busy       = (state_q != IDLE);
  assign push_req   = wr && sel_tx;
  assign push       = push_req && !full;
  assign pop        = (state_q == IDLE) && !empty;
  assign baud_end   = (baud_q == BAUD_LAST);

  // FIFO, status and control registers
  always_comb begin
    mem_d    = mem_q;
    wptr_d   = wptr_q;
    rptr_d   = rptr_q;
    cnt_d    = cnt_q;
    ovf_d    = ovf_q;
    irq_en_d = irq_en_q;
    if (push) begin
      mem_d[wptr_q] = wdata[7:0];
      wptr_d        = wptr_q + 2'd1;
    end
    if (pop) begin
      rptr_d = rptr_q + 2'd1;
    end
    case ({push, pop})
      2'b10:   cnt_d = cnt_q + 3'd1;
      2'b01:   cnt_d = cnt_q - 3'd1;
      default: cnt_d = cnt_q;
    endcase
    // A rejected push wins over a clear arriving in the same cycle.
    if (push_req && full) begin
      ovf_d = 1'b1;
    end else if (wr && sel_status && wdata[3]) begin
      ovf_d = 1'b0;
    end
    if (wr && sel_ctrl) begin
      irq_en_d = wdata[0];
    end
    irq_d = irq_en_q && empty && (state_q == IDLE);
  end

  // Transmitter next state; the line is registered from the next state.
  always_comb begin
    state_d = state_q;
    baud_d  = baud_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    case (state_q)
      IDLE: begin
        if (pop) begin
          shift_d = mem_q[rptr_q];
          baud_d  = 16'd0;
          state_d = START;
        end
      end
      START: begin
        if (baud_end) begin
          baud_d  = 16'd0;
          bit_d   = 3'd0;
          state_d = DATA;
        end else begin
          baud_d = baud_q + 16'd1;
        end
      end
      DATA: begin
        if (baud_end) begin
          baud_d  = 16'd0;
          shift_d = shift_q >> 1;
          if (bit_q == 3'd7) begin
            state_d = STOP;
          end else begin
            bit_d = bit_q + 3'd1;
          end
        end else begin
          baud_d = baud_q + 16'd1;
        end
      end
      STOP: begin
        if (baud_end) begin
          baud_d  = 16'd0;
          state_d = IDLE;
        end else begin
          baud_d = baud_q + 16'd1;
        end
      end
      default: state_d = IDLE;
    endcase
    case (state_d)
      START:   tx_d = 1'b0;
      DATA:    tx_d = shift_d[0];
      default: tx_d = 1'b1;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= IDLE;
      baud_q   <= '0;
      bit_q    <= '0;
      shift_q  <= '0;
      tx_q     <= 1'b1;
      irq_q    <= 1'b0;
      ovf_q    <= 1'b0;
      irq_en_q <= 1'b0;
      wptr_q   <= '0;
      rptr_q   <= '0;
      cnt_q    <= '0;
      for (int i = 0; i < 4; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      state_q  <= state_d;
      baud_q   <= baud_d;
      bit_q    <= bit_d;
      shift_q  <= shift_d;
      tx_q     <= tx_d;
      irq_q    <= irq_d;
      ovf_q    <= ovf_d;
      irq_en_q <= irq_en_d;
      wptr_q   <= wptr_d;
      rptr_q   <= rptr_d;
      cnt_q    <= cnt_d;
      mem_q    <= mem_d;
    end
  end

  always_comb begin
    rdata = '0;
    if (rd) begin
      if (sel_status) begin
        rdata = {25'd0, cnt_q, ovf_q, empty, full, busy};
      end else if (sel_ctrl) begin
        rdata = {31'd0, irq_en_q};
      end
    end
  end

  assign uart_tx = tx_q;
  assign irq     = irq_q;

endmodule

// File: tb/tb_mmio_uart_tx.sv
// Bench for mmio_uart_tx: a frame-level model (byte queue plus a frame-time
// countdown) predicts line, irq and register reads every cycle.
module tb_mmio_uart_tx;

  localparam int BD = 4;
  localparam int FRAME = 10 * BD;
  localparam logic [31:0] A_TX   = 32'h4000_0030;
  localparam logic [31:0] A_ST   = 32'h4000_0034;
  localparam logic [31:0] A_CTRL = 32'h4000_0038;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        rd = 1'b0;
  logic        wr = 1'b0;
  logic [31:0] addr = '0;
  logic [31:0] wdata = '0;
  logic [31:0] rdata;
  logic        uart_tx;
  logic        irq;

  int total = 0;
  int bad = 0;

  // Model state: waiting bytes, byte on the wire, cycles left in its frame.
  logic [7:0] m_q[$];
  logic [7:0] m_cur;
  int         m_rem;
  logic       m_ovf, m_en, m_irq;

  mmio_uart_tx #(.BAUD_DIV(BD)) dut (
    .clk(clk), .reset(reset), .rd(rd), .wr(wr), .addr(addr),
    .wdata(wdata), .rdata(rdata), .uart_tx(uart_tx), .irq(irq)
  );

  always #5 clk = ~clk;

  task automatic model_reset();
    m_q.delete();
    m_cur = '0;
    m_rem = 0;
    m_ovf = 1'b0;
    m_en  = 1'b0;
    m_irq = 1'b0;
  endtask

  function automatic logic m_line();
    int k;
    if (m_rem == 0) return 1'b1;
    k = (FRAME - m_rem) / BD;
    if (k == 0) return 1'b0;
    if (k <= 8) return m_cur[k-1];
    return 1'b1;
  endfunction

  function automatic logic [31:0] m_rdata(input logic r, input logic [31:0] a);
    logic [31:0] s;
    s = '0;
    if (!r) return s;
    if (a == A_ST) begin
      s[0]   = (m_rem > 0);
      s[1]   = (m_q.size() == 4);
      s[2]   = (m_q.size() == 0);
      s[3]   = m_ovf;
      s[6:4] = 3'(m_q.size());
    end else if (a == A_CTRL) begin
      s[0] = m_en;
    end
    return s;
  endfunction

  task automatic model_step(input logic w, input logic [31:0] a, input logic [31:0] d);
    logic irq_nx, full;
    irq_nx = m_en && (m_q.size() == 0) && (m_rem == 0);
    full   = (m_q.size() == 4);
    if (w && a == A_TX && full) m_ovf = 1'b1;
    else if (w && a == A_ST && d[3]) m_ovf = 1'b0;
    if (w && a == A_CTRL) m_en = d[0];
    if (m_rem == 0 && m_q.size() > 0) begin
      m_cur = m_q.pop_front();
      m_rem = FRAME;
    end else if (m_rem > 0) begin
      m_rem--;
    end
    if (w && a == A_TX && !full) m_q.push_back(d[7:0]);
    m_irq = irq_nx;
  endtask

  // One bus cycle: drive at negedge, clock it, leave the time 2 units after the edge.
  task automatic cycle(input logic w, input logic r, input logic [31:0] a, input logic [31:0] d);
    @(negedge clk);
    wr = w; rd = r; addr = a; wdata = d;
    @(posedge clk);
    model_step(w, a, d);
    #2;
  endtask

  task automatic test_reset();
    model_reset();
    repeat (3) @(posedge clk);
    #2;
    rd = 1'b1; addr = A_ST;
    #1;
    total++;
    if (uart_tx !== 1'b1) begin bad++; $display("FAIL reset_tx got=%b exp=1", uart_tx); end
    total++;
    if (irq !== 1'b0) begin bad++; $display("FAIL reset_irq got=%b exp=0", irq); end
    total++;
    if (rdata !== 32'h4) begin bad++; $display("FAIL reset_status got=%h exp=00000004", rdata); end
    @(negedge clk);
    reset = 1'b1;
    rd = 1'b0;
  endtask

  task automatic test_single_frame();
    cycle(1'b1, 1'b0, A_TX, 32'h0000_00A5);
    for (int i = 0; i < FRAME + 4; i++) begin
      cycle(1'b0, 1'b1, A_ST, 32'h0);
      total++;
      if (uart_tx !== m_line()) begin
        bad++; $display("FAIL a5_line cyc=%0d got=%b exp=%b", i, uart_tx, m_line());
      end
      total++;
      if (rdata !== m_rdata(1'b1, A_ST)) begin
        bad++; $display("FAIL a5_status cyc=%0d got=%h exp=%h", i, rdata, m_rdata(1'b1, A_ST));
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0] vals[6] = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66};
    for (int i = 0; i < 5; i++) cycle(1'b1, 1'b0, A_TX, {24'd0, vals[i]});
    cycle(1'b0, 1'b1, A_ST, 32'h0);
    total++;
    if (rdata[6:3] !== 4'b1000) begin
      bad++; $display("FAIL b2b_fill got_cnt=%0d got_ovf=%b exp_cnt=4 exp_ovf=0", rdata[6:4], rdata[3]);
    end
    cycle(1'b1, 1'b0, A_TX, {24'd0, vals[5]});
    cycle(1'b0, 1'b1, A_ST, 32'h0);
    total++;
    if (rdata[3] !== 1'b1) begin bad++; $display("FAIL b2b_ovf got=%b exp=1", rdata[3]); end
    for (int i = 0; i < 5 * (FRAME + 1) + 6; i++) begin
      cycle(1'b0, 1'b1, A_ST, 32'h0);
      total++;
      if (uart_tx !== m_line()) begin
        bad++; $display("FAIL b2b_line cyc=%0d got=%b exp=%b", i, uart_tx, m_line());
      end
      total++;
      if (rdata !== m_rdata(1'b1, A_ST)) begin
        bad++; $display("FAIL b2b_status cyc=%0d got=%h exp=%h", i, rdata, m_rdata(1'b1, A_ST));
      end
    end
  endtask

  task automatic test_ovf_clear();
    cycle(1'b1, 1'b0, A_ST, 32'h7);
    cycle(1'b0, 1'b1, A_ST, 32'h0);
    total++;
    if (rdata !== 32'h0000_000C) begin bad++; $display("FAIL ovf_keep got=%h exp=0000000c", rdata); end
    cycle(1'b1, 1'b0, A_ST, 32'h8);
    cycle(1'b0, 1'b1, A_ST, 32'h0);
    total++;
    if (rdata !== 32'h0000_0004) begin bad++; $display("FAIL ovf_clear got=%h exp=00000004", rdata); end
  endtask

  task automatic test_irq();
    cycle(1'b1, 1'b0, A_CTRL, 32'hFFFF_FFFF);
    cycle(1'b0, 1'b1, A_CTRL, 32'h0);
    total++;
    if (rdata !== 32'h1) begin bad++; $display("FAIL ctrl_read got=%h exp=00000001", rdata); end
    total++;
    if (irq !== 1'b1) begin bad++; $display("FAIL irq_idle got=%b exp=1", irq); end
    cycle(1'b1, 1'b0, A_TX, 32'h0000_003C);
    for (int i = 0; i < FRAME + 6; i++) begin
      cycle(1'b0, 1'b0, A_ST, 32'h0);
      total++;
      if (irq !== m_irq) begin bad++; $display("FAIL irq_frame cyc=%0d got=%b exp=%b", i, irq, m_irq); end
      total++;
      if (uart_tx !== m_line()) begin
        bad++; $display("FAIL irq_line cyc=%0d got=%b exp=%b", i, uart_tx, m_line());
      end
    end
    cycle(1'b1, 1'b0, A_CTRL, 32'h0);
    cycle(1'b0, 1'b0, A_ST, 32'h0);
    total++;
    if (irq !== 1'b0) begin bad++; $display("FAIL irq_disable got=%b exp=0", irq); end
  endtask

  task automatic test_read_decode();
    logic [31:0] addrs[5] = '{A_ST, 32'h4000_003C, A_TX, 32'h4000_0035, 32'hC000_0034};
    logic        rds[5]   = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
    for (int i = 0; i < 5; i++) begin
      cycle(1'b0, rds[i], addrs[i], 32'h0);
      total++;
      if (rdata !== 32'h0) begin bad++; $display("FAIL rd_decode idx=%0d got=%h exp=00000000", i, rdata); end
    end
    cycle(1'b1, 1'b0, 32'h4000_0031, 32'h0000_0077);
    cycle(1'b0, 1'b1, A_ST, 32'h0);
    total++;
    if (rdata !== 32'h4) begin bad++; $display("FAIL unmapped_wr got=%h exp=00000004", rdata); end
  endtask

  task automatic test_reset_mid();
    cycle(1'b1, 1'b0, A_TX, 32'h0000_0000);
    cycle(1'b1, 1'b0, A_TX, 32'h0000_0099);
    for (int i = 0; i < 3 * BD; i++) cycle(1'b0, 1'b0, A_ST, 32'h0);
    total++;
    if (uart_tx !== 1'b0) begin bad++; $display("FAIL mid_pre got=%b exp=0", uart_tx); end
    #1;
    reset = 1'b0;
    #1;
    total++;
    if (uart_tx !== 1'b1) begin bad++; $display("FAIL mid_async got=%b exp=1", uart_tx); end
    rd = 1'b1; addr = A_ST;
    #1;
    total++;
    if (rdata !== 32'h4) begin bad++; $display("FAIL mid_status got=%h exp=00000004", rdata); end
    model_reset();
    @(negedge clk);
    reset = 1'b1;
    for (int i = 0; i < FRAME + 10; i++) begin
      cycle(1'b0, 1'b1, A_ST, 32'h0);
      total++;
      if (uart_tx !== 1'b1 || rdata !== 32'h4) begin
        bad++; $display("FAIL mid_residual cyc=%0d tx=%b status=%h exp_tx=1 exp_status=00000004", i, uart_tx, rdata);
      end
    end
  endtask

  task automatic test_random();
    logic [31:0] ra[6] = '{A_TX, A_ST, A_CTRL, 32'h4000_003C, 32'h4000_0031, 32'h0000_0034};
    logic [31:0] a, d;
    int op;
    for (int i = 0; i < 1500; i++) begin
      op = $urandom_range(0, 99);
      d  = $urandom();
      a  = ra[$urandom_range(0, 5)];
      if (op < 8) cycle(1'b1, 1'b0, A_TX, d);
      else if (op < 11) cycle(1'b1, 1'b0, A_ST, d);
      else if (op < 14) cycle(1'b1, 1'b0, A_CTRL, d);
      else if (op < 16) cycle(1'b1, 1'b0, a, d);
      else cycle(1'b0, 1'($urandom_range(0, 7) != 0), (op < 60) ? A_ST : a, 32'h0);
      total++;
      if (uart_tx !== m_line()) begin
        bad++; $display("FAIL rnd_line cyc=%0d got=%b exp=%b", i, uart_tx, m_line());
      end
      total++;
      if (irq !== m_irq) begin bad++; $display("FAIL rnd_irq cyc=%0d got=%b exp=%b", i, irq, m_irq); end
      total++;
      if (rdata !== m_rdata(rd, addr)) begin
        bad++; $display("FAIL rnd_rdata cyc=%0d addr=%h got=%h exp=%h", i, addr, rdata, m_rdata(rd, addr));
      end
    end
  endtask

  initial begin
    test_reset();
    test_single_frame();
    test_back_to_back();
    test_ovf_clear();
    test_irq();
    test_read_decode();
    test_reset_mid();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mmio_uart_tx.md
MMIO_UART_TX -- requirements
Module: mmio_uart_tx

Interface
REQ-001 The block SHALL have parameter BAUD_DIV, default 10417: clk cycles per UART bit (100 MHz / 9600), legal range 2..65535.
REQ-002 The block SHALL have port clk, input, 1 bit: the single system clock; all state updates on its rising edge.
REQ-003 The block SHALL have port reset, input, 1 bit: asynchronous, active-low reset.
REQ-004 The block SHALL have port rd, input, 1 bit: bus read strobe from the MEM stage.
REQ-005 The block SHALL have port wr, input, 1 bit: bus write strobe from the MEM stage.
REQ-006 The block SHALL have port addr, input, 32 bits: byte address of the access.
REQ-007 The block SHALL have port wdata, input, 32 bits: write data.
REQ-008 The block SHALL have port rdata, output, 32 bits: read data, combinational.
REQ-009 The block SHALL have port uart_tx, output, 1 bit: serial line, registered, idle high.
REQ-010 The block SHALL have port irq, output, 1 bit: level interrupt request.

Function
REQ-011 The block SHALL decode on a full 32-bit address match:
- 0x40000030 TXDATA
- 0x40000034 STATUS
- 0x40000038 CTRL
All other addresses SHALL be ignored.
REQ-012 A wr to TXDATA SHALL push wdata[7:0] into a 4-entry FIFO at the clock edge when the FIFO is not full.
REQ-013 A wr to TXDATA while the FIFO is full (count==4 before the edge) SHALL drop the byte and set sticky overflow, even if a pop occurs in the same cycle.
REQ-014 A simultaneous accepted push and pop SHALL leave count unchanged and preserve FIFO order; pointers SHALL be 2 bits and wrap 3->0.
REQ-015 STATUS read SHALL return:
- bit0 busy (state!=IDLE)
- bit1 full
- bit2 empty
- bit3 overflow
- bits[6:4] count (0..4)
- other bits 0
REQ-016 A wr to STATUS with wdata[3]=1 SHALL clear overflow; an overflow set in the same cycle SHALL take priority.
REQ-017 CTRL bit0 SHALL be irq_en, writable and readable; other CTRL bits SHALL read 0.
REQ-018 A TXDATA read SHALL return 0; rdata SHALL be 0 whenever rd=0 or the address is unmapped.
REQ-019 The transmitter FSM SHALL have states IDLE, START, DATA and STOP.
REQ-020 In IDLE with count>0, the FSM SHALL pop the FIFO head into an 8-bit shift register at the edge, clear the baud counter and enter START.
REQ-021 uart_tx SHALL be 1 in IDLE and STOP, 0 in START, and the current shift LSB in DATA.
REQ-022 Each bit period SHALL last exactly BAUD_DIV cycles, counted 0..BAUD_DIV-1.
REQ-023 DATA SHALL send 8 bits LSB-first; a 3-bit counter SHALL advance per period and the FSM SHALL exit to STOP after bit 7.
REQ-024 After one STOP period the FSM SHALL return to IDLE, giving a frame of 10*BAUD_DIV cycles plus at least 1 idle-high cycle between frames.
REQ-025 irq SHALL equal irq_en AND empty AND state==IDLE, registered, updating one cycle after the condition changes.
REQ-026 Bus writes SHALL never stall; the block SHALL have no wait states.

Reset
REQ-027 While reset=0 the block SHALL hold:
- uart_tx=1, irq=0
- FSM IDLE, all counters 0
- FIFO empty with pointers 0
- overflow=0, irq_en=0
REQ-028 Reset asserted mid-frame SHALL force uart_tx high immediately and discard the frame and all FIFO contents.

Verification
REQ-029 With BAUD_DIV=4, write 0xA5 to TXDATA -> uart_tx low 4 cycles starting the cycle after the pop, then 1,0,1,0,0,1,0,1 at 4 cycles each, then high 4 cycles; busy=1 for all 40 cycles.
REQ-030 Write 0x11, 0x22, 0x33, 0x44, 0x55 back-to-back -> 0x11 is popped immediately and 0x22..0x55 fill the FIFO, so all five are accepted, overflow stays 0, and five frames follow in order; a sixth write while count==4 sets STATUS bit3=1 and that byte is never sent.
REQ-031 Write STATUS=0x8 after overflow -> STATUS bit3 reads 0; a same-cycle overflow keeps the bit at 1.
REQ-032 Set CTRL=1, send one byte -> irq=0 while busy; irq=1 one cycle after returning to IDLE with the FIFO empty; irq=0 after CTRL=0.
REQ-033 Assert reset mid-DATA -> uart_tx=1 asynchronously, STATUS reads 0x4, and no residual frame follows release.
REQ-034 rd of 0x40000034 with rd=0, or rd of 0x4000003C -> rdata=0.
